bpsk_rx_frame_ctrl: RTL
=======================

// Module: bpsk_rx_frame_ctrl
// PURPOSE
//  Sequencer for the BPSK receive datapath (NCO + CORDIC mixer + integrate-and-dump).
//  Generates symbol_tick and the NCO phase_step, samples the demodulated bit stream,
//  hunts for a sync word (either polarity), then frames a fixed-length payload into
//  bytes. Sits between the rx datapath and the byte-level consumer.
// PARAMETERS
//  SPS_W     16        width of samples-per-symbol config
//  SYNC_W    16        sync word length in bits
//  SYNC_WORD 16'hD391  sync pattern, transmitted MSB first
//  LAT       17        cycles from symbol_tick to valid bit_in (16 CORDIC delay + 1 reg)
//  LEN_W     8         payload length counter width (bytes)
// PORTS
//  clk            in   1       clock
//  rst            in   1       asynchronous, active-high reset
//  en             in   1       run enable; low forces IDLE
//  sps            in   SPS_W   samples per symbol; values <2 treated as 2
//  phase_step_cfg in   32      NCO step requested by software
//  payload_len    in   LEN_W   payload bytes per frame, sampled at sync match
//  bit_in         in   1       demodulated bit from rx datapath
//  phase_step     out  32      NCO step driven to datapath
//  symbol_tick    out  1       1-cycle dump strobe to datapath
//  byte_out       out  8       assembled payload byte
//  byte_valid     out  1       1-cycle strobe, byte_out valid
//  frame_done     out  1       1-cycle strobe, last payload byte delivered
//  locked         out  1       high in PAYLOAD state
//  inverted       out  1       sync matched with inverted polarity
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters/shift regs cleared.
//  - States: IDLE, HUNT, PAYLOAD, DONE.
//  - IDLE->HUNT when en=1; phase_step <= phase_step_cfg on that transition only;
//    held constant until next IDLE exit (config changes mid-frame ignored).
//  - Symbol counter runs in every non-IDLE state: 0..sps_eff-1; symbol_tick=1
//    in the cycle counter==sps_eff-1, then counter wraps to 0. First tick
//    sps_eff cycles after leaving IDLE. sps changes take effect at wrap.
//  - Bit strobe = symbol_tick delayed LAT cycles; bit_in sampled on strobe only.
//  - HUNT: sr <= {sr[SYNC_W-2:0], bit_in} per strobe; after >=SYNC_W strobes,
//    sr==SYNC_WORD -> PAYLOAD, inverted=0; sr==~SYNC_WORD -> PAYLOAD, inverted=1.
//    Latch payload_len; byte/bit counters cleared. payload_len==0 -> DONE directly.
//  - PAYLOAD: bits XOR inverted, shifted into byte MSB first; on 8th strobe
//    byte_out updates and byte_valid pulses the next cycle. When byte count
//    reaches latched length -> DONE, same cycle as last byte_valid.
//  - DONE: frame_done=1 for one cycle, inverted cleared, then HUNT with sr
//    cleared and strobe count reset (no overlap of sync with prior payload).
//  - en=0 in any state: IDLE on next edge; counters, delay line and pending
//    strobes flushed; no byte_valid/frame_done emitted. en=0 wins over a
//    coincident strobe.
//  - symbol_tick continues through DONE/HUNT so the integrator never stalls.
//  - Reset mid-frame: immediate return to reset values; no partial byte output.
// STRUCTURE
//  - Shared package: state encoding (IDLE/HUNT/PAYLOAD/DONE), default SYNC_WORD,
//    LAT constant (CORDIC latency + 1) shared with the rx datapath.
//  - One sub-module: existing delay line (WIDTH=1, DEPTH=LAT) for the bit strobe,
//    with a flush on en=0 (OR-gated clear, not reset).
// TESTING
//  1 sps=8, en rises: first symbol_tick at cycle 8, then every 8; phase_step=cfg.
//  2 Stream 0xD391 then 0xA5,0x3C, len=2 -> locked, bytes A5,3C, frame_done
//    with 2nd byte_valid+1, back to HUNT.
//  3 Stream 0x2C6E (inverted sync) then 0x5A -> inverted=1, byte_out=0xA5.
//  4 len=0 after sync -> frame_done one cycle after DONE entry, no byte_valid.
//  5 en=0 mid-payload after 4 bits -> IDLE next edge, no byte_valid; re-enable
//    re-hunts; phase_step_cfg change during frame not reflected until re-enable.
//  6 sps=1 -> tick every 2 cycles; async rst mid-frame -> all outputs 0 at once.

Source files
------------

// File: rtl/bpsk_rx_frame_ctrl_pkg.sv
// Shared constants and state encoding for the BPSK rx frame sequencer and rx datapath.
package bpsk_rx_frame_ctrl_pkg;

   localparam int unsigned CordicLat    = 16;
   localparam int unsigned RxLat        = CordicLat + 1;
   localparam logic [15:0] SyncWordDflt = 16'hD391;

   typedef enum logic [1:0] {
      StIdle,
      StHunt,
      StPayload,
      StDone
   } rx_state_e;

endpackage

// File: rtl/bpsk_rx_frame_ctrl_delay.sv
// Fixed-depth delay line with a synchronous flush that clears every stage.
module bpsk_rx_frame_ctrl_delay #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 17
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] pipe_q [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= din;
         for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/bpsk_rx_frame_ctrl.sv
// BPSK rx sequencer: symbol timing, NCO step hold, sync hunt (either polarity), payload framing.
module bpsk_rx_frame_ctrl
   import bpsk_rx_frame_ctrl_pkg::*;
#(
   parameter int unsigned       SPS_W     = 16,
   parameter int unsigned       SYNC_W    = 16,
   parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(SyncWordDflt),
   parameter int unsigned       LAT       = RxLat,
   parameter int unsigned       LEN_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [SPS_W-1:0] sps,
   input  logic [31:0]      phase_step_cfg,
   input  logic [LEN_W-1:0] payload_len,
   input  logic             bit_in,
   output logic [31:0]      phase_step,
   output logic             symbol_tick,
   output logic [7:0]       byte_out,
   output logic             byte_valid,
   output logic             frame_done,
   output logic             locked,
   output logic             inverted
);

   localparam int unsigned SyncCntW = $clog2(SYNC_W + 1);

   rx_state_e             state_q, state_d;
   logic [SPS_W-1:0]      sym_cnt_q, sym_cnt_d;
   logic [SPS_W-1:0]      sps_lat_q, sps_lat_d;
   logic [31:0]           phase_q, phase_d;
   logic [SYNC_W-2:0]     sync_sr_q, sync_sr_d;
   logic [SyncCntW-1:0]   sync_cnt_q, sync_cnt_d;
   logic [LEN_W-1:0]      len_q, len_d;
   logic [LEN_W-1:0]      byte_cnt_q, byte_cnt_d;
   logic [2:0]            bit_cnt_q, bit_cnt_d;
   logic [6:0]            byte_sr_q, byte_sr_d;
   logic [7:0]            byte_out_q, byte_out_d;
   logic                  byte_valid_q, byte_valid_d;
   logic                  frame_done_q, frame_done_d;
   logic                  inverted_q, inverted_d;

   logic [SPS_W-1:0]      sps_eff;
   logic [SYNC_W-1:0]     sync_shift;
   logic [SyncCntW-1:0]   sync_cnt_inc;
   logic [7:0]            byte_shift;
   logic                  strobe;

   assign sps_eff      = (sps < SPS_W'(2)) ? SPS_W'(2) : sps;
   assign symbol_tick  = (state_q != StIdle) && (sym_cnt_q == sps_lat_q - SPS_W'(1));
   // Registers hold only the older bits; the newest bit is appended combinationally.
   assign sync_shift   = {sync_sr_q, bit_in};
   assign byte_shift   = {byte_sr_q, bit_in ^ inverted_q};
   assign sync_cnt_inc = (sync_cnt_q == SyncCntW'(SYNC_W)) ? sync_cnt_q
                                                            : sync_cnt_q + SyncCntW'(1);

   bpsk_rx_frame_ctrl_delay #(
      .WIDTH (1),
      .DEPTH (LAT)
   ) u_strobe_dly (
      .clk   (clk),
      .rst   (rst),
      .flush (~en),
      .din   (symbol_tick),
      .dout  (strobe)
   );

   always_comb begin
      state_d      = state_q;
      sym_cnt_d    = sym_cnt_q + SPS_W'(1);
      sps_lat_d    = sps_lat_q;
      phase_d      = phase_q;
      sync_sr_d    = sync_sr_q;
      sync_cnt_d   = sync_cnt_q;
      len_d        = len_q;
      byte_cnt_d   = byte_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      byte_sr_d    = byte_sr_q;
      byte_out_d   = byte_out_q;
      byte_valid_d = 1'b0;
      frame_done_d = 1'b0;
      inverted_d   = inverted_q;

      // New sps only applies from a wrap so the current symbol keeps its length.
      if (state_q == StIdle || symbol_tick) begin
         sym_cnt_d = '0;
         sps_lat_d = sps_eff;
      end

      unique case (state_q)
         StIdle: begin
            if (en) begin
               state_d = StHunt;
               phase_d = phase_step_cfg;
            end
         end
         StHunt: begin
            if (strobe) begin
               sync_sr_d  = sync_shift[SYNC_W-2:0];
               sync_cnt_d = sync_cnt_inc;
               if (sync_cnt_inc == SyncCntW'(SYNC_W) &&
                   (sync_shift == SYNC_WORD || sync_shift == ~SYNC_WORD)) begin
                  inverted_d = (sync_shift != SYNC_WORD);
                  len_d      = payload_len;
                  byte_cnt_d = '0;
                  bit_cnt_d  = '0;
                  state_d    = (payload_len == '0) ? StDone : StPayload;
               end
            end
         end
         StPayload: begin
            if (strobe) begin
               byte_sr_d = byte_shift[6:0];
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  byte_out_d   = byte_shift;
                  byte_valid_d = 1'b1;
                  byte_cnt_d   = byte_cnt_q + LEN_W'(1);
                  if (byte_cnt_q + LEN_W'(1) == len_q) state_d = StDone;
               end
            end
         end
         StDone: begin
            frame_done_d = 1'b1;
            inverted_d   = 1'b0;
            sync_sr_d    = '0;
            sync_cnt_d   = '0;
            state_d      = StHunt;
         end
         default: state_d = StIdle;
      endcase

      // Disable overrides everything, including a strobe landing in the same cycle.
      if (!en) begin
         state_d      = StIdle;
         sym_cnt_d    = '0;
         sync_sr_d    = '0;
         sync_cnt_d   = '0;
         byte_cnt_d   = '0;
         bit_cnt_d    = '0;
         byte_sr_d    = '0;
         byte_out_d   = byte_out_q;
         byte_valid_d = 1'b0;
         frame_done_d = 1'b0;
         inverted_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         sym_cnt_q    <= '0;
         sps_lat_q    <= SPS_W'(2);
         phase_q      <= '0;
         sync_sr_q    <= '0;
         sync_cnt_q   <= '0;
         len_q        <= '0;
         byte_cnt_q   <= '0;
         bit_cnt_q    <= '0;
         byte_sr_q    <= '0;
         byte_out_q   <= '0;
         byte_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
         inverted_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         sym_cnt_q    <= sym_cnt_d;
         sps_lat_q    <= sps_lat_d;
         phase_q      <= phase_d;
         sync_sr_q    <= sync_sr_d;
         sync_cnt_q   <= sync_cnt_d;
         len_q        <= len_d;
         byte_cnt_q   <= byte_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         byte_sr_q    <= byte_sr_d;
         byte_out_q   <= byte_out_d;
         byte_valid_q <= byte_valid_d;
         frame_done_q <= frame_done_d;
         inverted_q   <= inverted_d;
      end
   end

   assign phase_step = phase_q;
   assign byte_out   = byte_out_q;
   assign byte_valid = byte_valid_q;
   assign frame_done = frame_done_q;
   assign locked     = (state_q == StPayload);
   assign inverted   = inverted_q;

endmodule
